// File: rtl/wb_sba_master.sv
// Wishbone B4 pipelined bus master for the debug module system-bus port.
// Converts a req/gnt/rvalid core interface into Wishbone cycles. Up to
// MaxOutstanding transfers may be in flight, and responses return in order.
// A watchdog aborts a hung bus and drains the in-flight transfers as error
// responses, so the debug module never deadlocks.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   core_req/we/addr/be/wdata  request from the DM core, held until core_gnt
//   core_gnt                request accepted this cycle (combinational)
//   core_rvalid/rdata/err   registered in-order response, one per grant
//   wbm_cyc/stb/we/adr/sel/dat_o  Wishbone master outputs (combinational)
//   wbm_stall/ack/err/dat_i Wishbone slave inputs
//   busy                    transfers in flight or flush in progress
//   timeout                 one-cycle pulse when the watchdog fires
module wb_sba_master #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [AddrWidth-1:0]   core_addr,
  input  logic [DataWidth/8-1:0] core_be,
  input  logic [DataWidth-1:0]   core_wdata,
  output logic                   core_gnt,
  output logic                   core_rvalid,
  output logic [DataWidth-1:0]   core_rdata,
  output logic                   core_err,
  output logic                   wbm_cyc,
  output logic                   wbm_stb,
  output logic                   wbm_we,
  output logic [AddrWidth-1:0]   wbm_adr,
  output logic [DataWidth/8-1:0] wbm_sel,
  output logic [DataWidth-1:0]   wbm_dat_o,
  input  logic                   wbm_stall,
  input  logic                   wbm_ack,
  input  logic                   wbm_err,
  input  logic [DataWidth-1:0]   wbm_dat_i,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned WdWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit          WdEn     = (TimeoutCycles != 0);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [CntWidth-1:0]       count_q, count_d;
  logic [WdWidth-1:0]        wd_q, wd_d;
  logic [MaxOutstanding-1:0] fifo_we_q, fifo_we_d;
  logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]       rd_ptr_q, rd_ptr_d;
  logic                      active_q;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [DataWidth-1:0]      rdata_q, rdata_d;
  logic                      timeout_q, timeout_d;

  logic can_issue;
  logic stb;
  logic gnt;
  logic cyc;
  logic bus_rsp;
  logic flush_pop;
  logic pop;
  logic head_we;

  // Issue and bus-response qualification. active_q keeps stb low while in
  // reset even if the core is already requesting.
  always_comb begin
    can_issue = active_q & (state_q == StRun) & (count_q < CntWidth'(MaxOutstanding));
    stb       = core_req & can_issue;
    gnt       = stb & ~wbm_stall;
    cyc       = (state_q == StRun) & (stb | (count_q != '0));
    // ack/err only count against a transfer that is actually outstanding
    bus_rsp   = cyc & (wbm_ack | wbm_err) & (count_q != '0);
    flush_pop = (state_q == StFlush) & (count_q != '0);
    pop       = bus_rsp | flush_pop;
    head_we   = fifo_we_q[rd_ptr_q];
  end

  // Next-state: pending FIFO, outstanding count, watchdog, response regs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wd_d      = wd_q;
    fifo_we_d = fifo_we_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    timeout_d = 1'b0;

    if (gnt) begin
      fifo_we_d[wr_ptr_q] = core_we;
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end

    // grant and response in the same cycle cancel out
    case ({gnt, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      StRun: begin
        if (bus_rsp) begin
          rvalid_d = 1'b1;
          err_d    = wbm_err;
          rdata_d  = (!head_we && !wbm_err) ? wbm_dat_i : '0;
        end
        if ((count_q == '0) || bus_rsp) begin
          wd_d = '0;
        end else if (WdEn) begin
          // this is the TimeoutCycles-th idle cycle: abort the bus
          if (wd_q == WdWidth'(TimeoutCycles - 1)) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            state_d   = StFlush;
          end else begin
            wd_d = wd_q + WdWidth'(1);
          end
        end
      end
      StFlush: begin
        wd_d = '0;
        if (flush_pop) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
        // last entry drains this cycle; issuing resumes next cycle
        if (count_q <= CntWidth'(1)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      count_q   <= '0;
      wd_q      <= '0;
      fifo_we_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      active_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wd_q      <= wd_d;
      fifo_we_q <= fifo_we_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      active_q  <= 1'b1;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs: bus request fields pass straight through from the core.
  assign core_gnt    = gnt;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign core_err    = err_q;
  assign wbm_cyc     = cyc;
  assign wbm_stb     = stb;
  assign wbm_we      = core_we;
  assign wbm_adr     = core_addr;
  assign wbm_sel     = core_be;
  assign wbm_dat_o   = core_wdata;
  assign busy        = (count_q != '0) | (state_q == StFlush);
  assign timeout     = timeout_q;

endmodule
